// File: rtl/crc10_pkg.sv
// Shared constants for the CRC-10 framer: polynomial, group boundaries,
// tail-field offsets, FSM encoding and counter width.
`timescale 1ns/1ps
package crc10_pkg;

    localparam int DATA_W = 62;
    localparam int CRC_W  = 10;
    localparam int CNT_W  = 22;

    // x^10+x^9+x^5+x^4+x+1 with the implicit x^10 term dropped
    localparam logic [CRC_W-1:0] CRC_POLY = 10'h233;

    localparam int G1_HI = 61;
    localparam int G1_LO = 47;
    localparam int G2_HI = 46;
    localparam int G2_LO = 32;
    localparam int G3_HI = 31;
    localparam int G3_LO = 16;
    localparam int G4_HI = 15;
    localparam int G4_LO = 0;

    localparam int G1_W = G1_HI - G1_LO + 1;
    localparam int G2_W = G2_HI - G2_LO + 1;
    localparam int G3_W = G3_HI - G3_LO + 1;
    localparam int G4_W = G4_HI - G4_LO + 1;

    localparam int TAIL_DATA_LO = 44;
    localparam int F1_HI = 43;
    localparam int F2_HI = 33;
    localparam int F3_HI = 23;
    localparam int F4_HI = 13;

    // On a tail word only the top bits of G2 (down to TAIL_DATA_LO) carry payload
    localparam logic [G2_W-1:0] G2_TAIL_MASK =
        {{(G2_HI - TAIL_DATA_LO + 1){1'b1}}, {(TAIL_DATA_LO - G2_LO){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/crc10_step.sv
// Combinational CRC-10 advance over one data group, MSB first.
// Bits whose bit_en is low are skipped (no shift).
`timescale 1ns/1ps
module crc10_step
    import crc10_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] bit_en,
    input  logic [CRC_W-1:0] lfsr_q,
    output logic [CRC_W-1:0] crc_out
);

    logic [CRC_W-1:0] acc;

    always_comb begin
        acc = lfsr_q;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (bit_en[i]) begin
                acc = {acc[CRC_W-2:0], 1'b0} ^
                      ({CRC_W{acc[CRC_W-1] ^ data_in[i]}} & CRC_POLY);
            end
        end
        crc_out = acc;
    end

endmodule

// File: rtl/crc10_gen.sv
// Four-group CRC-10 framer: passes body words through and rewrites the tail
// word with per-group CRC fields; one registered output stage.
`timescale 1ns/1ps
module crc10_gen
    import crc10_pkg::*;
(
    input  logic              clk_390p625M,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_eof,
    output logic              in_ready,
    input  logic              err_inject,
    output logic [DATA_W-1:0] crc10_data_out,
    output logic              crc10_en,
    output logic              frame_tail_flag,
    output logic [CNT_W-1:0]  tx_frame_cnt,
    output logic              protocol_err
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    state_t                       state_p1;
    logic [3:0][CRC_W-1:0]        lfsr_p1;
    logic [DATA_W-1:0]            data_p1;
    logic                         vld_p1;
    logic                         tail_p1;
    logic [CNT_W-1:0]             cnt_p1;
    logic                         perr_p1;

    logic                         accept_p0;
    logic                         take_p0;
    logic                         viol_p0;
    logic [3:0][CRC_W-1:0]        seed_p0;
    logic [3:0][CRC_W-1:0]        lfsr_nxt_p0;
    logic [G2_W-1:0]              g2_en_p0;
    logic [G3_W-1:0]              g3_en_p0;
    logic [G4_W-1:0]              g4_en_p0;
    logic [DATA_W-1:0]            tail_word_p0;

    // p0: accept decode, LFSR seed and per-group advance
    assign in_ready  = (state_p1 != GAP);
    assign accept_p0 = in_valid & in_ready;
    assign take_p0   = accept_p0 & ((state_p1 == BODY) | in_sof);
    assign viol_p0   = accept_p0 & (((state_p1 == IDLE) & ~in_sof) |
                                    ((state_p1 == BODY) &  in_sof));

    // A new frame (or a restart by sof mid-frame) always starts from seed 0
    assign seed_p0  = ((state_p1 == IDLE) | in_sof) ? '0 : lfsr_p1;
    assign g2_en_p0 = in_eof ? G2_TAIL_MASK : '1;
    assign g3_en_p0 = in_eof ? '0 : '1;
    assign g4_en_p0 = in_eof ? '0 : '1;

    crc10_step #(.WIDTH(G1_W)) u_step_g1 (
        .data_in (in_data[G1_HI:G1_LO]),
        .bit_en  ({G1_W{1'b1}}),
        .lfsr_q  (seed_p0[0]),
        .crc_out (lfsr_nxt_p0[0])
    );

    crc10_step #(.WIDTH(G2_W)) u_step_g2 (
        .data_in (in_data[G2_HI:G2_LO]),
        .bit_en  (g2_en_p0),
        .lfsr_q  (seed_p0[1]),
        .crc_out (lfsr_nxt_p0[1])
    );

    crc10_step #(.WIDTH(G3_W)) u_step_g3 (
        .data_in (in_data[G3_HI:G3_LO]),
        .bit_en  (g3_en_p0),
        .lfsr_q  (seed_p0[2]),
        .crc_out (lfsr_nxt_p0[2])
    );

    crc10_step #(.WIDTH(G4_W)) u_step_g4 (
        .data_in (in_data[G4_HI:G4_LO]),
        .bit_en  (g4_en_p0),
        .lfsr_q  (seed_p0[3]),
        .crc_out (lfsr_nxt_p0[3])
    );

    always_comb begin
        tail_word_p0 = '0;
        tail_word_p0[DATA_W-1:TAIL_DATA_LO] = in_data[DATA_W-1:TAIL_DATA_LO];
        tail_word_p0[F1_HI -: CRC_W] = lfsr_nxt_p0[0] ^ {{(CRC_W-1){1'b0}}, err_inject};
        tail_word_p0[F2_HI -: CRC_W] = lfsr_nxt_p0[1];
        tail_word_p0[F3_HI -: CRC_W] = lfsr_nxt_p0[2];
        tail_word_p0[F4_HI -: CRC_W] = lfsr_nxt_p0[3];
    end

    // p1: output register, LFSR state, FSM, counters
    always_ff @(posedge clk_390p625M or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= IDLE;
            lfsr_p1  <= '0;
            data_p1  <= '0;
            vld_p1   <= 1'b0;
            tail_p1  <= 1'b0;
            cnt_p1   <= '0;
            perr_p1  <= 1'b0;
        end else begin
            vld_p1  <= take_p0;
            tail_p1 <= take_p0 & in_eof;
            if (take_p0) begin
                data_p1 <= in_eof ? tail_word_p0 : in_data;
                lfsr_p1 <= in_eof ? '0 : lfsr_nxt_p0;
            end
            if (take_p0 && in_eof)
                cnt_p1 <= sat_inc(cnt_p1);
            if (viol_p0)
                perr_p1 <= 1'b1;

            unique case (state_p1)
                IDLE, BODY: if (take_p0) state_p1 <= in_eof ? GAP : BODY;
                GAP:        state_p1 <= IDLE;
                default:    state_p1 <= IDLE;
            endcase
        end
    end

    assign crc10_data_out  = data_p1;
    assign crc10_en        = vld_p1;
    assign frame_tail_flag = tail_p1;
    assign tx_frame_cnt    = cnt_p1;
    assign protocol_err    = perr_p1;

endmodule

// File: tb/tb_crc10_gen.sv
// Bench for crc10_gen: constant vector table, random frames against a
// polynomial-division model, and a far-end residue checker on the output.
`timescale 1ns/1ps
module tb_crc10_gen;
    import crc10_pkg::*;

    logic              clk_390p625M = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_sof;
    logic              in_eof;
    logic              in_ready;
    logic              err_inject;
    logic [DATA_W-1:0] crc10_data_out;
    logic              crc10_en;
    logic              frame_tail_flag;
    logic [CNT_W-1:0]  tx_frame_cnt;
    logic              protocol_err;

    always #1.28 clk_390p625M = ~clk_390p625M;

    crc10_gen dut (
        .clk_390p625M    (clk_390p625M),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_sof          (in_sof),
        .in_eof          (in_eof),
        .in_ready        (in_ready),
        .err_inject      (err_inject),
        .crc10_data_out  (crc10_data_out),
        .crc10_en        (crc10_en),
        .frame_tail_flag (frame_tail_flag),
        .tx_frame_cnt    (tx_frame_cnt),
        .protocol_err    (protocol_err)
    );

    typedef struct {
        logic [61:0] data;
        logic        err;
        logic [61:0] exp;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    int          fe_err = 0;
    logic        fe_last_ok = 1'b0;
    logic [61:0] fe_words[$];
    logic [61:0] frm[$];
    logic [10:0] gen_poly = 11'h633;
    vec_t        tbl[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Remainder of (bits * x^10) mod g by long division, first bit = highest power
    function automatic logic [9:0] poly_rem(input bit q[$]);
        bit          w[$];
        logic [9:0]  r;
        w = q;
        for (int i = 0; i < 10; i++) w.push_back(1'b0);
        for (int i = 0; i + 10 < w.size(); i++)
            if (w[i])
                for (int j = 0; j <= 10; j++) w[i+j] ^= gen_poly[10-j];
        for (int j = 0; j < 10; j++) r[9-j] = w[w.size()-10+j];
        return r;
    endfunction

    function automatic logic [61:0] model_tail(input bit err);
        bit          g1[$], g2[$], g3[$], g4[$];
        logic [61:0] w, r;
        int          n;
        n = frm.size();
        for (int k = 0; k < n; k++) begin
            w = frm[k];
            for (int b = 61; b >= 47; b--) g1.push_back(w[b]);
            if (k < n - 1) begin
                for (int b = 46; b >= 32; b--) g2.push_back(w[b]);
                for (int b = 31; b >= 16; b--) g3.push_back(w[b]);
                for (int b = 15; b >= 0;  b--) g4.push_back(w[b]);
            end else begin
                for (int b = 46; b >= 44; b--) g2.push_back(w[b]);
            end
        end
        r = '0;
        r[61:44] = frm[n-1][61:44];
        r[43:34] = poly_rem(g1) ^ {9'b0, err};
        r[33:24] = poly_rem(g2);
        r[23:14] = poly_rem(g3);
        r[13:4]  = poly_rem(g4);
        return r;
    endfunction

    // Receiver view: data bits followed by the received CRC must leave zero residue
    function automatic bit fe_check(input logic [61:0] ws[$]);
        bit          g1[$], g2[$], g3[$], g4[$];
        logic [61:0] w;
        int          n;
        n = ws.size();
        if (n == 0) return 1'b0;
        for (int k = 0; k < n - 1; k++) begin
            w = ws[k];
            for (int b = 61; b >= 47; b--) g1.push_back(w[b]);
            for (int b = 46; b >= 32; b--) g2.push_back(w[b]);
            for (int b = 31; b >= 16; b--) g3.push_back(w[b]);
            for (int b = 15; b >= 0;  b--) g4.push_back(w[b]);
        end
        w = ws[n-1];
        for (int b = 61; b >= 47; b--) g1.push_back(w[b]);
        for (int b = 43; b >= 34; b--) g1.push_back(w[b]);
        for (int b = 46; b >= 44; b--) g2.push_back(w[b]);
        for (int b = 33; b >= 24; b--) g2.push_back(w[b]);
        for (int b = 23; b >= 14; b--) g3.push_back(w[b]);
        for (int b = 13; b >= 4;  b--) g4.push_back(w[b]);
        return (poly_rem(g1) == 0) && (poly_rem(g2) == 0) &&
               (poly_rem(g3) == 0) && (poly_rem(g4) == 0) && (w[3:0] == 4'h0);
    endfunction

    always @(negedge clk_390p625M) begin
        if (!rst_n) begin
            fe_words.delete();
        end else if (crc10_en) begin
            fe_words.push_back(crc10_data_out);
            if (frame_tail_flag) begin
                fe_last_ok <= fe_check(fe_words);
                fe_err     <= fe_err + (fe_check(fe_words) ? 0 : 1);
                fe_words.delete();
            end
        end
    end

    function automatic logic [61:0] rnd62();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[61:0];
    endfunction

    task automatic drive(input logic [61:0] d, input logic s, input logic e, input logic er);
        int st;
        st = 0;
        in_valid = 1'b1; in_data = d; in_sof = s; in_eof = e; err_inject = er;
        while (!in_ready && st < 8) begin
            @(posedge clk_390p625M); #0.2;
            st++;
        end
        if (!in_ready) chk("ready_wait", in_ready, 1);
        @(posedge clk_390p625M); #0.2;
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; err_inject = 1'b0;
    endtask

    task automatic send_frame(input bit err, input int bub_at, input int bub_len,
                              output logic [61:0] got);
        int n;
        n = frm.size();
        for (int k = 0; k < n; k++) begin
            drive(frm[k], k == 0, k == n - 1, err && (k == n - 1));
            if (k == bub_at && k < n - 1) begin
                for (int j = 0; j < bub_len; j++) begin
                    @(posedge clk_390p625M); #0.2;
                    chk("bubble_en", crc10_en, 0);
                end
            end
        end
        got = crc10_data_out;
        chk("tail_word", got, model_tail(err));
        chk("tail_flag", frame_tail_flag, 1);
    endtask

    task automatic rand_frame(input int n);
        frm.delete();
        for (int k = 0; k < n; k++) frm.push_back(rnd62());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [61:0] clean, errd, bub, got, one34;
        logic [61:0] saved[$];
        int          base;
        logic [21:0] cnt0;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sof = 1'b0;
        in_eof = 1'b0; err_inject = 1'b0;
        repeat (3) @(posedge clk_390p625M);
        #0.2;
        chk("rst_data", crc10_data_out, 0);
        chk("rst_en", crc10_en, 0);
        chk("rst_tail", frame_tail_flag, 0);
        chk("rst_cnt", tx_frame_cnt, 0);
        chk("rst_perr", protocol_err, 0);
        rst_n = 1'b1;
        @(posedge clk_390p625M); #0.2;
        chk("rst_ready", in_ready, 1);

        // Single-word frames with hand-derived tails
        tbl[0] = '{62'h0,                 1'b0, 62'h0};
        tbl[1] = '{62'h0000_1000_0000_0000, 1'b0, 62'h0000_1002_3300_0000};
        tbl[2] = '{62'h0000_8000_0000_0000, 1'b0, 62'h0000_88CC_0000_0000};
        tbl[3] = '{62'h0000_8000_0000_0000, 1'b1, 62'h0000_88C8_0000_0000};
        tbl[4] = '{62'h0,                 1'b1, 62'h0000_0004_0000_0000};
        tbl[5] = '{62'h0000_0FFF_FFFF_FFFF, 1'b0, 62'h0};
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].data, 1'b1, 1'b1, tbl[i].err);
            chk("vec_word", crc10_data_out, tbl[i].exp);
            chk("vec_en", crc10_en, 1);
            chk("vec_flag", frame_tail_flag, 1);
            chk("vec_cnt", tx_frame_cnt, i + 1);
            chk("vec_ready_gap", in_ready, 0);
            @(posedge clk_390p625M); #0.2;
            chk("vec_en_after", crc10_en, 0);
            chk("vec_ready_after", in_ready, 1);
        end

        // 8 random words plus tail, clean then with injected error
        rand_frame(9);
        saved = frm;
        @(negedge clk_390p625M); #0.2;
        base = fe_err;
        send_frame(1'b0, -1, 0, clean);
        @(negedge clk_390p625M); #0.2;
        chk("fe_clean_ok", fe_last_ok, 1);
        chk("fe_clean_err", fe_err - base, 0);

        frm = saved;
        base = fe_err;
        send_frame(1'b1, -1, 0, errd);
        @(negedge clk_390p625M); #0.2;
        one34 = '0; one34[34] = 1'b1;
        chk("err_bit34", errd ^ clean, one34);
        chk("fe_err_inc", fe_err - base, 1);

        frm = saved;
        send_frame(1'b0, 3, 3, bub);
        chk("bubble_same", bub, clean);

        // Back-to-back frames with in_valid held high across the gap
        base = fe_err;
        rand_frame(3);
        send_frame(1'b0, -1, 0, got);
        rand_frame(4);
        in_valid = 1'b1; in_data = frm[0]; in_sof = 1'b1;
        chk("b2b_ready_gap", in_ready, 0);
        @(posedge clk_390p625M); #0.2;
        chk("b2b_en_gap", crc10_en, 0);
        chk("b2b_ready_back", in_ready, 1);
        send_frame(1'b0, -1, 0, got);
        @(negedge clk_390p625M); #0.2;
        chk("b2b_fe", fe_err - base, 0);

        // Randomized frame lengths and bubbles
        base = fe_err;
        for (int f = 0; f < 12; f++) begin
            rand_frame($urandom_range(1, 6));
            send_frame(1'b0, $urandom_range(0, 4), $urandom_range(0, 2), got);
        end
        @(negedge clk_390p625M); #0.2;
        chk("rand_fe", fe_err - base, 0);

        // sof while in BODY abandons the first frame
        chk("perr_before", protocol_err, 0);
        rand_frame(3);
        for (int k = 0; k < 3; k++) drive(frm[k], k == 0, 1'b0, 1'b0);
        cnt0 = tx_frame_cnt;
        rand_frame(4);
        send_frame(1'b0, -1, 0, got);
        chk("sofmid_perr", protocol_err, 1);
        chk("sofmid_cnt", tx_frame_cnt, cnt0 + 1);

        // Reset mid-frame, then a word without sof is dropped
        rand_frame(2);
        drive(frm[0], 1'b1, 1'b0, 1'b0);
        drive(frm[1], 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #0.2;
        chk("mid_rst_data", crc10_data_out, 0);
        chk("mid_rst_en", crc10_en, 0);
        chk("mid_rst_cnt", tx_frame_cnt, 0);
        chk("mid_rst_perr", protocol_err, 0);
        @(posedge clk_390p625M); #0.2;
        rst_n = 1'b1;
        drive(rnd62(), 1'b0, 1'b0, 1'b0);
        chk("drop_en", crc10_en, 0);
        chk("drop_perr", protocol_err, 1);
        chk("drop_ready", in_ready, 1);
        rand_frame(2);
        send_frame(1'b0, -1, 0, got);
        chk("post_rst_cnt", tx_frame_cnt, 1);

        // Counter saturation from a preloaded value
        @(posedge clk_390p625M); #0.2;
        force dut.cnt_p1 = 22'h3FFFFE;
        #0.2;
        release dut.cnt_p1;
        #0.2;
        chk("sat_preload", tx_frame_cnt, 22'h3FFFFE);
        for (int i = 0; i < 3; i++) begin
            rand_frame(1);
            send_frame(1'b0, -1, 0, got);
            chk("sat_cnt", tx_frame_cnt, 22'h3FFFFF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
